// File: rtl/pbvi_belief_update.sv
// pbvi_belief_update
// Two-state POMDP belief update for point-based value iteration.
// Given the current belief P(s0) (Q1.15), an action and an observation, it
// predicts the state distribution through the transition table T, weights it
// with the observation table O, and normalises with a 16-cycle restoring
// divider to produce the posterior belief.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (ready only while idle)
//   in_b0                current P(s0), Q1.15, values above 1.0 are clamped
//   in_action            0..2 valid actions, 3 is rejected with out_err
//   in_obs               observation o0 (0) or o1 (1)
//   out_valid/out_ready  result handshake, result held until consumed
//   out_b0, out_b1       posterior P(s0) and P(s1) = 1.0 - P(s0)
//   out_err              bad action or zero normaliser; out_b0 = input belief
//   cfg_we/addr/data     table writes, accepted only while idle
//                        addr[3]=0 -> T[a][s], addr[3]=1 -> O[a][s'], idx 2a+s
//   busy                 high whenever the block is not idle
module pbvi_belief_update #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_b0,
  input  logic [1:0]    in_action,
  input  logic          in_obs,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_b0,
  output logic [DW-1:0] out_b1,
  output logic          out_err,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          busy
);

  localparam logic [DW-1:0] ONE  = DW'(32'h8000);
  localparam logic [DW-1:0] HALF = DW'(32'h4000);

  typedef enum logic [2:0] {IDLE, PRED, WGT, DIV, OUT} state_t;

  state_t        state_q;
  logic [DW-1:0] t_q [6];
  logic [DW-1:0] o_q [6];

  logic [DW-1:0] b0_q;
  logic          invalid_q;
  logic [DW-1:0] tA_q, tB_q, oA_q, oB_q;
  logic [DW-1:0] p0_q;
  logic [16:0]   den_q;
  logic [16:0]   rem_q;
  logic          lsb_q;
  logic [14:0]   quot_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] outB0_q, outB1_q;
  logic          outErr_q, outValid_q;

  logic [DW-1:0] selT0, selT1, selO0, selO1;
  logic [DW-1:0] b0Clamp;
  logic [DW-1:0] b1;
  logic [17:0]   pSum;
  logic [DW-1:0] p0_d, p1;
  logic [DW-1:0] w0_d, w1_d;
  logic [16:0]   den_d;
  logic [17:0]   trial;
  logic          ge;
  logic [16:0]   remNext;
  logic [15:0]   quotNext;
  logic [DW-1:0] qClamp;

  // Table entries for the requested action. The four entries are snapshotted
  // at acceptance, so a same-edge cfg write or later writes never disturb the
  // transaction in flight.
  always_comb begin
    selT0 = '0;
    selT1 = '0;
    selO0 = '0;
    selO1 = '0;
    case (in_action)
      2'd0: begin selT0 = t_q[0]; selT1 = t_q[1]; selO0 = o_q[0]; selO1 = o_q[1]; end
      2'd1: begin selT0 = t_q[2]; selT1 = t_q[3]; selO0 = o_q[2]; selO1 = o_q[3]; end
      2'd2: begin selT0 = t_q[4]; selT1 = t_q[5]; selO0 = o_q[4]; selO1 = o_q[5]; end
      default: ;
    endcase
  end

  assign b0Clamp = (in_b0 > ONE) ? ONE : in_b0;

  // Arithmetic for PRED, WGT and one restoring-division step. Products are
  // 16x16 and truncated by the >>15 back into Q1.15.
  always_comb begin
    b1    = ONE - b0_q;
    pSum  = 18'(({16'b0, b0_q} * {16'b0, tA_q}) >> 15)
          + 18'(({16'b0, b1} * {16'b0, tB_q}) >> 15);
    p0_d  = (pSum > 18'h08000) ? ONE : pSum[15:0];
    p1    = ONE - p0_q;
    w0_d  = 16'(({16'b0, p0_q} * {16'b0, oA_q}) >> 15);
    w1_d  = 16'(({16'b0, p1} * {16'b0, oB_q}) >> 15);
    den_d = {1'b0, w0_d} + {1'b0, w1_d};
    // Dividend is w0<<15: its upper part (w0>>1) seeds the remainder and the
    // only non-zero low bit (w0[0]) is shifted in on the first step.
    trial    = {rem_q, (cnt_q == 4'd0) ? lsb_q : 1'b0};
    ge       = (trial >= {1'b0, den_q});
    remNext  = ge ? 17'(trial - {1'b0, den_q}) : trial[16:0];
    quotNext = {quot_q, ge};
    qClamp   = (quotNext > ONE) ? ONE : quotNext;
  end

  // Model tables; writes land only while idle, addresses 6 and 7 are unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        t_q[i] <= HALF;
        o_q[i] <= HALF;
      end
    end else if (cfg_we && (state_q == IDLE) && (cfg_addr[2:0] < 3'd6)) begin
      if (cfg_addr[3]) o_q[cfg_addr[2:0]] <= cfg_data;
      else             t_q[cfg_addr[2:0]] <= cfg_data;
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b0_q       <= '0;
      invalid_q  <= 1'b0;
      tA_q       <= '0;
      tB_q       <= '0;
      oA_q       <= '0;
      oB_q       <= '0;
      p0_q       <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      lsb_q      <= 1'b0;
      quot_q     <= '0;
      cnt_q      <= '0;
      outB0_q    <= ONE;
      outB1_q    <= '0;
      outErr_q   <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            b0_q      <= b0Clamp;
            invalid_q <= (in_action == 2'd3);
            tA_q      <= selT0;
            tB_q      <= selT1;
            // Observation o1 uses the complement probability 1.0 - O.
            oA_q      <= in_obs ? (ONE - selO0) : selO0;
            oB_q      <= in_obs ? (ONE - selO1) : selO1;
            state_q   <= PRED;
          end
        end
        PRED: begin
          if (invalid_q) begin
            outB0_q    <= b0_q;
            outB1_q    <= ONE - b0_q;
            outErr_q   <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= OUT;
          end else begin
            p0_q    <= p0_d;
            state_q <= WGT;
          end
        end
        WGT: begin
          if (den_d == 17'd0) begin
            outB0_q    <= b0_q;
            outB1_q    <= ONE - b0_q;
            outErr_q   <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= OUT;
          end else begin
            den_q   <= den_d;
            rem_q   <= {2'b00, w0_d[15:1]};
            lsb_q   <= w0_d[0];
            quot_q  <= '0;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q  <= remNext;
          quot_q <= quotNext[14:0];
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            outB0_q    <= qClamp;
            outB1_q    <= ONE - qClamp;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign out_b0    = outB0_q;
  assign out_b1    = outB1_q;
  assign out_err   = outErr_q;

endmodule

// File: tb/tb_pbvi_belief_update.sv
// tb_pbvi_belief_update
// Drives directed and random belief-update requests into pbvi_belief_update
// and compares every result, its latency and its hold behaviour against a
// plain-arithmetic model of the two-state Bayes update kept in this bench.
module tb_pbvi_belief_update;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_b0 = '0;
  logic [1:0]  in_action = '0;
  logic        in_obs = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_b0;
  logic [15:0] out_b1;
  logic        out_err;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        busy;

  int nCompared = 0;
  int nMismatched = 0;

  logic [15:0] mT [6];
  logic [15:0] mO [6];

  logic        expErr;
  logic [15:0] expB0;
  int          expLat;
  logic [15:0] lastB0;
  logic        lastErr;
  int          lastLat;

  pbvi_belief_update #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_b0(in_b0), .in_action(in_action), .in_obs(in_obs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_b0(out_b0), .out_b1(out_b1), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 6; i++) begin
      mT[i] = 16'h4000;
      mO[i] = 16'h4000;
    end
  endtask

  // Posterior from Bayes' rule with Q1.15 truncation at each product.
  function automatic void modelUpdate(input logic [15:0] b0in, input logic [1:0] a,
                                      input logic o, output logic err,
                                      output logic [15:0] nb, output int lat);
    longint b0, b1, p0, p1, oe0, oe1, w0, w1, den, q;
    int base;
    b0 = (b0in > 16'h8000) ? 64'd32768 : longint'(b0in);
    if (a == 2'd3) begin
      err = 1'b1; nb = 16'(b0); lat = 1;
      return;
    end
    base = 2 * int'(a);
    b1 = 32768 - b0;
    p0 = (b0 * longint'(mT[base])) / 32768 + (b1 * longint'(mT[base+1])) / 32768;
    if (p0 > 32768) p0 = 32768;
    p1 = 32768 - p0;
    oe0 = o ? 32768 - longint'(mO[base])   : longint'(mO[base]);
    oe1 = o ? 32768 - longint'(mO[base+1]) : longint'(mO[base+1]);
    w0 = (p0 * oe0) / 32768;
    w1 = (p1 * oe1) / 32768;
    den = w0 + w1;
    if (den == 0) begin
      err = 1'b1; nb = 16'(b0); lat = 2;
      return;
    end
    q = (w0 * 32768) / den;
    if (q > 32768) q = 32768;
    err = 1'b0; nb = 16'(q); lat = 18;
  endfunction

  task automatic cfgWrite(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (addr[2:0] < 3'd6) begin
      if (addr[3]) mO[addr[2:0]] = data;
      else         mT[addr[2:0]] = data;
    end
  endtask

  // Presents one request; expectation is taken from the tables as they are
  // before any same-edge cfg write.
  task automatic applyStimulus(input logic [15:0] b0, input logic [1:0] a, input logic o,
                               input bit early, input bit cfgSame,
                               input logic [3:0] cAddr, input logic [15:0] cData);
    for (int k = 0; k < 60 && !in_ready; k++) @(negedge clk);
    @(negedge clk);
    checkVal("in_ready before request", in_ready, 1);
    in_valid = 1'b1; in_b0 = b0; in_action = a; in_obs = o;
    if (cfgSame) begin
      cfg_we = 1'b1; cfg_addr = cAddr; cfg_data = cData;
    end
    modelUpdate(b0, a, o, expErr, expB0, expLat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    if (early) out_ready = 1'b1;
    if (cfgSame && cAddr[2:0] < 3'd6) begin
      if (cAddr[3]) mO[cAddr[2:0]] = cData;
      else          mT[cAddr[2:0]] = cData;
    end
  endtask

  // Waits for the result, checks it against the model, holds it for a while
  // (optionally attempting a cfg write) and then consumes it.
  task automatic checkOutput(input string tag, input int hold, input bit cfgDuring,
                             input logic [3:0] cAddr, input logic [15:0] cData);
    int lat;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    lastLat = lat; lastB0 = out_b0; lastErr = out_err;
    checkVal({tag, " latency"}, lat, expLat);
    if (lat != 0) begin
      checkVal({tag, " out_b0"}, out_b0, expB0);
      checkVal({tag, " out_b1"}, out_b1, 16'h8000 - expB0);
      checkVal({tag, " out_err"}, out_err, expErr);
      checkVal({tag, " in_ready in OUT"}, in_ready, 0);
      checkVal({tag, " busy in OUT"}, busy, 1);
      for (int h = 0; h < hold; h++) begin
        if (cfgDuring && h == 1) begin
          cfg_we = 1'b1; cfg_addr = cAddr; cfg_data = cData;
        end
        @(posedge clk);
        #1 cfg_we = 1'b0;
        checkVal({tag, " held out_valid"}, out_valid, 1);
        checkVal({tag, " held out_b0"}, out_b0, expB0);
        checkVal({tag, " held out_err"}, out_err, expErr);
        checkVal({tag, " held in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkVal({tag, " out_valid after handshake"}, out_valid, 0);
      checkVal({tag, " in_ready after handshake"}, in_ready, 1);
      checkVal({tag, " busy after handshake"}, busy, 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  ra;
    logic [15:0] rd;
    logic [15:0] rb;
    bit          early;
    int          seen;

    $display("[TB] start");
    resetModel();

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset in_ready", in_ready, 1);
    checkVal("reset out_valid", out_valid, 0);
    checkVal("reset out_b0", out_b0, 16'h8000);
    checkVal("reset out_b1", out_b1, 16'h0000);
    checkVal("reset out_err", out_err, 0);
    checkVal("reset busy", busy, 0);

    // Reset tables: certain s0, a1, o0
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("base", 0, 0, 4'd0, 16'd0);
    checkVal("base literal b0", lastB0, 16'h4000);
    checkVal("base literal lat", lastLat, 18);

    // Deterministic transition, informative observation
    cfgWrite(4'd2, 16'h8000);
    cfgWrite(4'd3, 16'h0000);
    cfgWrite(4'd10, 16'h6000);
    cfgWrite(4'd11, 16'h2000);
    applyStimulus(16'h4000, 2'd1, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("a2 half", 1, 0, 4'd0, 16'd0);
    checkVal("a2 half literal b0", lastB0, 16'h6000);
    applyStimulus(16'h8000, 2'd1, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("a2 full", 0, 0, 4'd0, 16'd0);
    checkVal("a2 full literal b0", lastB0, 16'h8000);

    // Zero normaliser
    cfgWrite(4'd12, 16'h8000);
    cfgWrite(4'd13, 16'h8000);
    applyStimulus(16'h1234, 2'd2, 1'b1, 0, 0, 4'd0, 16'd0);
    checkOutput("zero den", 2, 0, 4'd0, 16'd0);
    checkVal("zero den literal err", lastErr, 1);
    checkVal("zero den literal b0", lastB0, 16'h1234);
    checkVal("zero den literal lat", lastLat, 2);

    // Invalid action
    applyStimulus(16'h2000, 2'd3, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("bad action", 0, 0, 4'd0, 16'd0);
    checkVal("bad action literal b0", lastB0, 16'h2000);
    checkVal("bad action literal lat", lastLat, 1);
    applyStimulus(16'hFFFF, 2'd3, 1'b1, 0, 0, 4'd0, 16'd0);
    checkOutput("bad action clamp", 0, 0, 4'd0, 16'd0);
    checkVal("bad action clamp literal b0", lastB0, 16'h8000);

    // Long hold with a dropped cfg write (T[0][0] would become 0)
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("hold5", 5, 1, 4'd0, 16'h0000);
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("after dropped write", 0, 0, 4'd0, 16'd0);
    checkVal("dropped write literal b0", lastB0, 16'h4000);

    // Same-edge write uses the old entry, the next request sees the new one
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 1, 4'd0, 16'h0000);
    checkOutput("same-edge write", 0, 0, 4'd0, 16'd0);
    checkVal("same-edge literal b0", lastB0, 16'h4000);
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("after same-edge write", 0, 0, 4'd0, 16'd0);
    checkVal("after same-edge literal b0", lastB0, 16'h0000);

    // Random requests and table updates
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0:       rd = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
          1:       rd = ra[3] ? 16'($urandom_range(0, 32768)) : 16'($urandom_range(0, 65535));
          default: rd = 16'($urandom_range(0, 32768));
        endcase
        cfgWrite(ra, rd);
      end
      rb = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 32768));
      early = ($urandom_range(0, 3) == 0);
      applyStimulus(rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), early, 0, 4'd0, 16'd0);
      checkOutput("random", early ? 0 : int'($urandom_range(0, 3)), 0, 4'd0, 16'd0);
    end

    // Reset in the middle of the division
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    repeat (8) @(posedge clk);
    #1 checkVal("busy mid-div", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("async reset out_valid", out_valid, 0);
    checkVal("async reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkVal("no result after abort", seen, 0);
    checkVal("post-reset out_b0", out_b0, 16'h8000);
    checkVal("post-reset in_ready", in_ready, 1);
    applyStimulus(16'h8000, 2'd0, 1'b0, 0, 0, 4'd0, 16'd0);
    checkOutput("post-reset", 0, 0, 4'd0, 16'd0);
    checkVal("post-reset literal b0", lastB0, 16'h4000);
    checkVal("post-reset literal lat", lastLat, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pbvi_belief_update.md
PBVI_BELIEF_UPDATE -- requirements
Module: pbvi_belief_update

Interface
REQ-001 SHALL have parameter DW, default 16, belief/probability word width; only 16 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  request valid.
REQ-005 SHALL have port in_ready  out  1  request accepted when in_valid&&in_ready at a rising edge.
REQ-006 SHALL have port in_b0  in  16  current belief P(s0), Q1.15 (0x8000=1.0); P(s1)=0x8000-b0.
REQ-007 SHALL have port in_action  in  2  action taken: 0=a1, 1=a2, 2=a3; 3 invalid.
REQ-008 SHALL have port in_obs  in  1  observation received, o0 or o1.
REQ-009 SHALL have port out_valid  out  1  result valid; held until out_ready.
REQ-010 SHALL have port out_ready  in  1  result consumed when out_valid&&out_ready at a rising edge.
REQ-011 SHALL have port out_b0  out  16  updated belief P(s0), Q1.15.
REQ-012 SHALL have port out_b1  out  16  0x8000-out_b0.
REQ-013 SHALL have port out_err  out  1  result invalid (bad action or zero normaliser).
REQ-014 SHALL have port cfg_we  in  1  model table write strobe.
REQ-015 SHALL have port cfg_addr  in  4  bit3=0: T table, bit3=1: O table; bits[2:0]=2*a+s (6,7 unused, ignored).
REQ-016 SHALL have port cfg_data  in  16  Q1.15 table entry; T[a][s]=P(s'=s0|s,a), O[a][s']=P(o0|s',a).
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM IDLE->PRED->WGT->DIV->OUT->IDLE; in_ready=1 only in IDLE.
REQ-019 SHALL capture in_b0 (values above 0x8000 clamped to 0x8000), in_action, in_obs on acceptance and go to PRED.
REQ-020 SHALL, in PRED, form p0=(b0*T[a][0]>>15)+(b1*T[a][1]>>15), each product truncated, p0 saturated to 0x8000; p1=0x8000-p0.
REQ-021 SHALL, in WGT, form for o0: w0=p0*O[a][0]>>15, w1=p1*O[a][1]>>15; for o1 use (0x8000-O[a][s']) instead; den=w0+w1 kept 17 bits.
REQ-022 SHALL, in DIV, compute nb0=(w0<<15)/den by restoring division, one quotient bit per cycle, 16 cycles; result truncated and clamped to 0x8000.
REQ-023 SHALL assert out_valid exactly 18 rising edges after the acceptance edge for a valid action (1 PRED + 1 WGT + 16 DIV).
REQ-024 SHALL, when den==0 at WGT exit, skip DIV, enter OUT with out_err=1, out_b0=captured b0, out_valid 2 edges after acceptance.
REQ-025 SHALL, when in_action==3, skip PRED/WGT/DIV, enter OUT on the next edge with out_err=1, out_b0=captured b0.
REQ-026 SHALL hold out_b0/out_b1/out_err/out_valid stable in OUT until out_ready; on handshake go to IDLE, out_valid=0 next cycle.
REQ-027 SHALL not accept a new request in the cycle the result handshake completes (in_ready rises the following cycle).
REQ-028 SHALL apply a cfg write only while in IDLE; writes in any other state are dropped; a write and acceptance on the same edge use the old table value.
REQ-029 SHALL ignore in_valid outside IDLE and out_ready outside OUT.

Reset
REQ-030 SHALL, on rst_n low, immediately go to IDLE: in_ready=1 after release, out_valid=0, out_b0=0x8000, out_b1=0, out_err=0, busy=0.
REQ-031 SHALL reset all 6 T and 6 O entries to 0x4000 (0.5).
REQ-032 SHALL abort any transaction in progress on reset with no result emitted.

Verification
REQ-033 SHALL cover: reset tables, b0=0x8000, a=0, o=0 -> out_b0=0x4000, out_b1=0x4000, err=0, 18 edges latency.
REQ-034 SHALL cover: T[1][0]=0x8000, T[1][1]=0, O[1][0]=0x6000, O[1][1]=0x2000; b0=0x4000, a=1, o=0 -> out_b0=0x6000; b0=0x8000 -> out_b0=0x8000.
REQ-035 SHALL cover: O[2][0]=O[2][1]=0x8000, a=2, o=1, b0=0x1234 -> out_err=1, out_b0=0x1234, out_valid 2 edges after acceptance.
REQ-036 SHALL cover: a=3, b0=0x2000 -> out_err=1, out_b0=0x2000 one edge after acceptance; in_b0=0xFFFF with a=3 -> out_b0=0x8000.
REQ-037 SHALL cover: out_ready low 5 cycles in OUT -> outputs stable, in_ready=0, cfg write during that time has no effect on the next result.
REQ-038 SHALL cover: rst_n pulsed low mid-DIV -> out_valid=0, tables back to 0x4000, next request yields REQ-033 result.
